// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the internal CPU bus arbiter and its helpers.
package cpu_bus_pkg;

    // Default bus geometry: four requesters (fetch, load/store, DMA, debug).
    localparam int DATAWIDTH_DEF = 16;
    localparam int REQS_DEF      = 4;
    localparam int SEL_DEF       = 2;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Turns a requester index into a one-hot request-shaped mask.
    function automatic logic [REQS_DEF-1:0] onehot(input logic [SEL_DEF-1:0] id);
        logic [REQS_DEF-1:0] mask;
        mask     = '0;
        mask[id] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/decoder.sv
// Parameterised binary-to-one-hot decoder cell with an enable.
module decoder #(
    parameter int SELW = 2
) (
    input  logic [SELW-1:0]      sel,
    input  logic                 en,
    output logic [(1<<SELW)-1:0] dec
);

    // One bit high at the selected position, all low when disabled.
    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/mux4x1.sv
// Parameterised four-input multiplexer cell.
module mux4x1 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Route the selected input straight through.
    always_comb begin
        y = in0;
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rr_pick
    import cpu_bus_pkg::*;
#(
    parameter int REQS = REQS_DEF,
    parameter int SEL  = SEL_DEF
) (
    input  logic [REQS-1:0] req,
    input  logic [REQS-1:0] exclude,
    input  logic [SEL-1:0]  ptr,
    output logic [SEL-1:0]  winner,
    output logic            any
);

    logic [REQS-1:0] eligible;
    logic [SEL-1:0]  idx;

    // Scan from ptr upward, wrapping through the SEL-bit index, and keep the first hit.
    always_comb begin
        eligible = req & ~exclude;
        winner   = '0;
        any      = 1'b0;
        idx      = ptr;
        for (int i = 0; i < REQS; i++) begin
            idx = ptr + SEL'(i);
            if (!any && eligible[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared internal CPU bus with bounded tenure.
module bus_arbiter_rr
    import cpu_bus_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int REQS      = REQS_DEF,
    parameter int SEL       = SEL_DEF,
    parameter int MAX_HOLD  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQS-1:0]           req,
    input  logic [REQS*DATAWIDTH-1:0] req_data,
    output logic [REQS-1:0]           gnt,
    output logic [SEL-1:0]            gnt_id,
    output logic                      gnt_valid,
    output logic [DATAWIDTH-1:0]      bus_data
);

    localparam int              HOLDW     = $clog2(MAX_HOLD);
    localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);

    state_t           state_q;
    logic [SEL-1:0]   gntId_q;
    logic             gntValid_q;
    logic [SEL-1:0]   ptr_q;
    logic [HOLDW-1:0] holdCnt_q;

    logic [REQS-1:0]      excludeMask;
    logic [SEL-1:0]       pickId;
    logic                 pickAny;
    logic                 ownerReq;
    logic [DATAWIDTH-1:0] muxOut;

    // While granted, the current owner is kept out of the search; on release its
    // request is already low, so the same picker serves release and preemption.
    always_comb begin
        excludeMask = '0;
        if (state_q == GRANT) begin
            excludeMask = REQS'(onehot(gntId_q));
        end
    end

    assign ownerReq = req[gntId_q];

    rr_pick #(
        .REQS (REQS),
        .SEL  (SEL)
    ) u_pick (
        .req     (req),
        .exclude (excludeMask),
        .ptr     (ptr_q),
        .winner  (pickId),
        .any     (pickAny)
    );

    // Arbitration FSM: release beats preemption beats keeping the current owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gntId_q    <= '0;
            gntValid_q <= 1'b0;
            ptr_q      <= '0;
            holdCnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        state_q    <= GRANT;
                        gntId_q    <= pickId;
                        gntValid_q <= 1'b1;
                        ptr_q      <= pickId + SEL'(1);
                        holdCnt_q  <= '0;
                    end
                end
                GRANT: begin
                    if (!ownerReq) begin
                        if (pickAny) begin
                            gntId_q   <= pickId;
                            ptr_q     <= pickId + SEL'(1);
                            holdCnt_q <= '0;
                        end else begin
                            state_q    <= IDLE;
                            gntValid_q <= 1'b0;
                            holdCnt_q  <= '0;
                        end
                    end else if ((holdCnt_q == HOLD_LAST) && pickAny) begin
                        gntId_q   <= pickId;
                        ptr_q     <= pickId + SEL'(1);
                        holdCnt_q <= '0;
                    end else if (holdCnt_q != HOLD_LAST) begin
                        holdCnt_q <= holdCnt_q + HOLDW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    gntValid_q <= 1'b0;
                end
            endcase
        end
    end

    // One-hot grant comes straight from the registered ID, so it can never
    // disagree with gnt_id and is all-zero whenever no grant is held.
    decoder #(
        .SELW (SEL)
    ) u_gntDec (
        .sel (gntId_q),
        .en  (gntValid_q),
        .dec (gnt)
    );

    mux4x1 #(
        .WIDTH (DATAWIDTH)
    ) u_busMux (
        .in0 (req_data[0*DATAWIDTH +: DATAWIDTH]),
        .in1 (req_data[1*DATAWIDTH +: DATAWIDTH]),
        .in2 (req_data[2*DATAWIDTH +: DATAWIDTH]),
        .in3 (req_data[3*DATAWIDTH +: DATAWIDTH]),
        .sel (gntId_q),
        .y   (muxOut)
    );

    assign gnt_id    = gntId_q;
    assign gnt_valid = gntValid_q;
    assign bus_data  = gntValid_q ? muxOut : '0;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed scenario bench for the round-robin bus arbiter.
module tb_bus_arbiter_rr;
    import cpu_bus_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
    logic [15:0] bus_data;

    int total;
    int bad;

    bus_arbiter_rr #(
        .DATAWIDTH (16),
        .REQS      (4),
        .SEL       (2),
        .MAX_HOLD  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .bus_data  (bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for driving and sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        tick();
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
        end
        total++;
        if (gnt_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_valid: got %b expected %b", gnt_valid, 1'b0);
        end
        total++;
        if (bus_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_bus: got %h expected %h", bus_data, 16'h0000);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL reset_release_gnt: got %b expected %b", gnt, 4'b0001);
        end
        total++;
        if (bus_data !== 16'hD000) begin
            bad++;
            $display("[TB] FAIL reset_release_bus: got %h expected %h", bus_data, 16'hD000);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        tick();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL single_gnt: got %b expected %b", gnt, 4'b0100);
        end
        total++;
        if (gnt_id !== 2'd2) begin
            bad++;
            $display("[TB] FAIL single_id: got %0d expected %0d", gnt_id, 2);
        end
        total++;
        if (bus_data !== 16'hBEEF) begin
            bad++;
            $display("[TB] FAIL single_bus: got %h expected %h", bus_data, 16'hBEEF);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (gnt !== 4'b0100) begin
                bad++;
                $display("[TB] FAIL single_hold[%0d]: got %b expected %b", c, gnt, 4'b0100);
            end
        end
        req = 4'b0000;
        tick();
        total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_drop: got gnt=%b valid=%b expected gnt=0000 valid=0", gnt, gnt_valid);
        end
        total++;
        if (bus_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL single_drop_bus: got %h expected %h", bus_data, 16'h0000);
        end
        total++;
        if (dut.state_q !== IDLE) begin
            bad++;
            $display("[TB] FAIL single_idle: got %0d expected %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] expGnt;
        int         owner;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            tick();
            owner  = (c / 8) % 4;
            expGnt = 4'b0001 << owner;
            total++;
            if (gnt !== expGnt || gnt_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL fair[%0d]: got gnt=%b valid=%b expected gnt=%b valid=1", c, gnt, gnt_valid, expGnt);
            end
        end
    endtask

    task automatic test_handover();
        do_reset();
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL hand_owner1: got %b expected %b", gnt, 4'b0010);
        end
        req = 4'b1010;
        tick();
        total++;
        if (gnt !== 4'b0010 || gnt_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hand_keep: got gnt=%b valid=%b expected gnt=0010 valid=1", gnt, gnt_valid);
        end
        req = 4'b1000;
        tick();
        total++;
        if (gnt !== 4'b1000 || gnt_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hand_new: got gnt=%b valid=%b expected gnt=1000 valid=1", gnt, gnt_valid);
        end
        total++;
        if (gnt_id !== 2'd3 || bus_data !== 16'hD333) begin
            bad++;
            $display("[TB] FAIL hand_id_bus: got id=%0d bus=%h expected id=3 bus=d333", gnt_id, bus_data);
        end
    endtask

    task automatic test_uncontended();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (gnt !== 4'b0001) begin
                bad++;
                $display("[TB] FAIL lone[%0d]: got %b expected %b", c, gnt, 4'b0001);
            end
        end
        total++;
        if (dut.holdCnt_q !== 3'd7) begin
            bad++;
            $display("[TB] FAIL lone_holdcnt: got %0d expected %0d", dut.holdCnt_q, 7);
        end
        req = 4'b0101;
        tick();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL lone_preempt: got %b expected %b", gnt, 4'b0100);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b1000;
        tick();
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL mid_owner3: got %b expected %b", gnt, 4'b1000);
        end
        rst_n = 1'b0;
        req   = 4'b1010;
        tick();
        total++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || bus_data !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL mid_clear: got gnt=%b valid=%b bus=%h expected 0000/0/0000", gnt, gnt_valid, bus_data);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            bad++;
            $display("[TB] FAIL mid_restart: got gnt=%b id=%0d expected gnt=0010 id=1", gnt, gnt_id);
        end
    endtask

    // Scenario sequence; every scenario starts from its own reset.
    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = {16'hD333, 16'hBEEF, 16'hD111, 16'hD000};
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_handover();
        test_uncontended();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
